vga_scanout: RTL



---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_timing.sv | 79 +++++++
 rtl/vga_scanout.sv | 109 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame-buffer scan-out path.
// Default timing is 640x480 @ 60 Hz driven from a 25 MHz pixel enable.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_DEPTH  = 19200;

  typedef logic [2:0] colour_t;

  // Eight vertical bars, each 20 source pixels wide: colour = x / 20.
  function automatic colour_t testpat_colour(input logic [7:0] x);
    colour_t c;
    c = '0;
    for (int i = 1; i < 8; i++) begin
      if (int'(x) >= 20 * i) c = colour_t'(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable phase, horizontal/vertical raster counters and the sync,
// visible-region and frame-start decode for the VGA scan-out.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clock,
  input  logic       resetn,
  output logic       pix_en,
  output logic       vga_clk,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hs_n,
  output logic       vs_n,
  output logic       visible,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic       phase_q, phase_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       fs_q, fs_d;

  always_comb begin
    phase_d = ~phase_q;
    h_d     = h_q;
    v_d     = v_q;
    fs_d    = 1'b0;
    if (pix_en) begin
      if (h_q == 10'(H_TOTAL - 1)) begin
        h_d = '0;
        if (v_q == 10'(V_TOTAL - 1)) begin
          v_d  = '0;
          fs_d = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      phase_q <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      fs_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fs_q    <= fs_d;
    end
  end

  assign pix_en      = phase_q;
  assign vga_clk     = phase_q;
  assign h           = h_q;
  assign v           = v_q;
  assign frame_start = fs_q;

  assign hs_n    = !((h_q >= 10'(H_ACTIVE + H_FP)) && (h_q < 10'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_n    = !((v_q >= 10'(V_ACTIVE + V_FP)) && (v_q < 10'(V_ACTIVE + V_FP + V_SYNC)));
  assign visible = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));

endmodule

// File: rtl/vga_scanout.sv
// Frame-buffer reader and VGA DAC driver: 160x120x3 buffer shown as 4x4 blocks.
// Optional SCANOUT_TESTPAT_EN adds a test_pattern input selecting colour bars.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        clock,
  input  logic        resetn,
`ifdef SCANOUT_TESTPAT_EN
  input  logic        test_pattern,
`endif
  output logic [14:0] rd_address,
  input  logic [2:0]  rd_data,
  output logic        frame_start,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B
);

  logic       pix_en, hs_n, vs_n, visible;
  logic [9:0] h, v;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clock       (clock),
    .resetn      (resetn),
    .pix_en      (pix_en),
    .vga_clk     (VGA_CLK),
    .h           (h),
    .v           (v),
    .hs_n        (hs_n),
    .vs_n        (vs_n),
    .visible     (visible),
    .frame_start (frame_start)
  );

  logic [7:0]  x;
  logic [6:0]  y;
  logic [14:0] y_ext;
  logic        unused_bits;

  assign x           = h[9:2];
  assign y           = v[8:2];
  assign y_ext       = {8'd0, y};
  assign unused_bits = ^{h[1:0], v[9], v[1:0]};

  // y*160 + x as shifts; forced to 0 during blanking so the RAM sees a legal address.
  assign rd_address = visible ? ((y_ext << 7) + (y_ext << 5) + {7'd0, x}) : '0;

  colour_t colour_src;
  colour_t colour_q, colour_d;
  logic    hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;

  always_comb begin
    colour_src = rd_data;
`ifdef SCANOUT_TESTPAT_EN
    if (test_pattern) colour_src = testpat_colour(x);
`endif
    colour_d  = colour_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    // rd_data for this pixel has arrived by the second clock of the pixel period.
    if (pix_en) begin
      colour_d  = visible ? colour_src : '0;
      hs_d      = hs_n;
      vs_d      = vs_n;
      blank_n_d = visible;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      colour_q  <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      colour_q  <= colour_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b1;
  assign VGA_R       = {10{colour_q[2]}};
  assign VGA_G       = {10{colour_q[1]}};
  assign VGA_B       = {10{colour_q[0]}};

endmodule
